// File: rtl/booth_fixed_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : booth_fixed_multiplier
//  Purpose  : Sequential radix-4 Booth multiplier. It retires two multiplier
//             bits per cycle and handles signed or unsigned operands, chosen
//             per operation. It returns the full 2N-bit product and an N-bit
//             Q-format result that is rounded and saturated.
//  Ports    : clk, reset (async, active-low)
//             in_valid / in_ready   - operand handshake (M, R, is_signed)
//             out_valid / out_ready - result handshake
//             product      - full 2N-bit product
//             fixed_result - product >> FRAC, rounded and saturated
//             overflow     - fixed_result was clamped
//  Revision : 1.0 - initial release
// ============================================================================
module booth_fixed_multiplier #(
   parameter int N     = 16,
   parameter int FRAC  = 10,
   parameter int ROUND = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     M,
   input  logic [N-1:0]     R,
   input  logic             is_signed,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*N-1:0]   product,
   output logic [N-1:0]     fixed_result,
   output logic             overflow
);

   localparam int K      = N/2 + 1;          // Booth iterations
   localparam int CW     = $clog2(K + 1);    // iteration counter width
   localparam int LW     = N + 2;            // extended operand width
   localparam int HW     = N + 4;            // upper partial product (holds +-2M plus growth)
   localparam int PW     = 2*N;              // product width
   localparam int TW     = 2*N + 1;          // product plus one guard bit
   localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
   localparam logic [TW-1:0] RND = ((ROUND != 0) && (FRAC > 0)) ? (TW'(1) << RND_SH) : '0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [HW-1:0]   hi_q;        // upper half of the accumulator
   logic [LW-1:0]   lo_q;        // multiplier, replaced by product bits as it shifts
   logic            prev_q;      // R[2i-1] of the current triplet
   logic [LW-1:0]   mcand_q;     // extended multiplicand
   logic            signed_q;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   product_q;
   logic [N-1:0]    fixed_q;
   logic            ovf_q;
   logic            out_valid_q;

   // ------------------------------------------------------------------
   // One Booth iteration: add the selected multiple, then shift right by 2
   // ------------------------------------------------------------------
   logic [2:0]      triplet_d;
   logic [HW-1:0]   m1_d, m2_d, addend_d, sum_d, hi_d;
   logic [LW-1:0]   lo_d;
   logic            prev_d;
   logic [PW-1:0]   prod_d;

   always_comb begin
      triplet_d = {lo_q[1], lo_q[0], prev_q};
      m1_d      = {{2{mcand_q[LW-1]}}, mcand_q};
      m2_d      = {m1_d[HW-2:0], 1'b0};
      addend_d  = '0;
      case (triplet_d)
         3'b001, 3'b010: addend_d = m1_d;
         3'b011:         addend_d = m2_d;
         3'b100:         addend_d = -m2_d;
         3'b101, 3'b110: addend_d = -m1_d;
         default:        addend_d = '0;
      endcase
      sum_d  = hi_q + addend_d;
      hi_d   = {{2{sum_d[HW-1]}}, sum_d[HW-1:2]};
      lo_d   = {sum_d[1:0], lo_q[LW-1:2]};
      prev_d = lo_q[1];
      // The true product always fits in 2N bits, in either mode
      prod_d = {hi_d[N-3:0], lo_d};
   end

   // ------------------------------------------------------------------
   // Fixed-point stage: round, shift, saturate
   // ------------------------------------------------------------------
   logic [TW-1:0]   t_d;
   logic [TW-1:0]   sh_d;
   logic [N-1:0]    fixed_d;
   logic            ovf_d;

   always_comb begin
      // The guard bit is a sign extension (signed) or a zero extension
      // (unsigned). Adding the rounding constant therefore cannot wrap.
      t_d     = {signed_q & prod_d[PW-1], prod_d} + RND;
      sh_d    = '0;
      fixed_d = '0;
      ovf_d   = 1'b0;
      if (signed_q) begin
         sh_d = $unsigned($signed(t_d) >>> FRAC);
         // The value fits only if bits TW-1..N-1 are all copies of the sign bit
         if ((&sh_d[TW-1:N-1]) || !(|sh_d[TW-1:N-1])) begin
            fixed_d = sh_d[N-1:0];
         end else begin
            ovf_d   = 1'b1;
            fixed_d = sh_d[TW-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
         end
      end else begin
         sh_d = t_d >> FRAC;
         if (|sh_d[TW-1:N]) begin
            ovf_d   = 1'b1;
            fixed_d = {N{1'b1}};
         end else begin
            fixed_d = sh_d[N-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM and registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         hi_q        <= '0;
         lo_q        <= '0;
         prev_q      <= 1'b0;
         mcand_q     <= '0;
         signed_q    <= 1'b0;
         cnt_q       <= '0;
         product_q   <= '0;
         fixed_q     <= '0;
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  mcand_q  <= {{2{M[N-1] & is_signed}}, M};
                  lo_q     <= {{2{R[N-1] & is_signed}}, R};
                  signed_q <= is_signed;
                  hi_q     <= '0;
                  prev_q   <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= S_CALC;
               end
            end
            S_CALC: begin
               hi_q   <= hi_d;
               lo_q   <= lo_d;
               prev_q <= prev_d;
               cnt_q  <= cnt_q + 1'b1;
               if (cnt_q == CW'(K - 1)) begin
                  product_q   <= prod_d;
                  fixed_q     <= fixed_d;
                  ovf_q       <= ovf_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready     = (state_q == S_IDLE);
   assign out_valid    = out_valid_q;
   assign product      = product_q;
   assign fixed_result = fixed_q;
   assign overflow     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_fixed_multiplier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_booth_fixed_multiplier
//  Purpose  : Self-checking bench for booth_fixed_multiplier (N=16, FRAC=10).
//             One instance rounds and the other truncates. Both share the
//             same stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_booth_fixed_multiplier;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready, in_ready_t;
   logic [15:0] M = '0;
   logic [15:0] R = '0;
   logic        is_signed = 1'b0;
   logic        out_valid, out_valid_t;
   logic        out_ready = 1'b0;
   logic [31:0] product, product_t;
   logic [15:0] fixed_result, fixed_result_t;
   logic        overflow, overflow_t;

   int n_checks = 0;
   int n_err    = 0;

   always #5 clk = ~clk;

   booth_fixed_multiplier #(.N(16), .FRAC(10), .ROUND(1)) u_dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .M(M), .R(R), .is_signed(is_signed), .out_valid(out_valid),
      .out_ready(out_ready), .product(product), .fixed_result(fixed_result),
      .overflow(overflow)
   );

   booth_fixed_multiplier #(.N(16), .FRAC(10), .ROUND(0)) u_dut_trunc (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
      .M(M), .R(R), .is_signed(is_signed), .out_valid(out_valid_t),
      .out_ready(out_ready), .product(product_t), .fixed_result(fixed_result_t),
      .overflow(overflow_t)
   );

   typedef struct {
      logic [15:0] m;
      logic [15:0] r;
      logic        sg;
      logic [31:0] p;
      logic [15:0] f1;   // ROUND=1 result
      logic        o1;
      logic [15:0] f0;   // ROUND=0 result
      logic        o0;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: exact integer product, then Q-format rules in 64-bit arithmetic
   function automatic void model(input logic [15:0] m, input logic [15:0] r,
                                 input logic sg, input bit rnd,
                                 output logic [31:0] p, output logic [15:0] f,
                                 output logic ov);
      longint a, b, pp, t, s;
      a  = sg ? longint'($signed(m)) : longint'({48'd0, m});
      b  = sg ? longint'($signed(r)) : longint'({48'd0, r});
      pp = a * b;
      p  = pp[31:0];
      t  = pp + (rnd ? 64'sd512 : 64'sd0);
      s  = t >>> 10;
      ov = 1'b0;
      if (sg) begin
         if (s > 32767)       begin f = 16'h7FFF; ov = 1'b1; end
         else if (s < -32768) begin f = 16'h8000; ov = 1'b1; end
         else                 f = s[15:0];
      end else begin
         if (s > 65535)       begin f = 16'hFFFF; ov = 1'b1; end
         else                 f = s[15:0];
      end
   endfunction

   task automatic run_op(input string nm, input logic [15:0] m, input logic [15:0] r,
                         input logic sg, input logic [31:0] ep,
                         input logic [15:0] ef1, input logic eo1,
                         input logic [15:0] ef0, input logic eo0, input int bp);
      int lat;
      int ir_bad;
      @(negedge clk);
      M = m; R = r; is_signed = sg; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      // Scramble the inputs after acceptance: they must not matter
      in_valid = 1'b0; M = 16'($urandom); R = 16'($urandom); is_signed = ~sg;
      lat = 0; ir_bad = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         if (in_ready !== 1'b0) ir_bad++;
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, "_latency"}, 64'(lat), 64'd9);
      chk({nm, "_in_ready_busy"}, 64'(ir_bad), 64'd0);
      chk({nm, "_product"}, 64'(product), 64'(ep));
      chk({nm, "_fixed_rnd"}, 64'({fixed_result, overflow}), 64'({ef1, eo1}));
      chk({nm, "_fixed_trunc"}, 64'({product_t, fixed_result_t, overflow_t}), 64'({ep, ef0, eo0}));
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         in_valid = 1'($urandom_range(0, 1)); M = 16'($urandom); R = 16'($urandom);
         @(posedge clk); #1;
         chk({nm, "_backpressure"},
             64'({out_valid, in_ready, product, fixed_result, overflow}),
             64'({1'b1, 1'b0, ep, ef1, eo1}));
      end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk({nm, "_handshake"}, 64'({out_valid, in_ready}), 64'(2'b01));
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ep;
      logic [15:0] ef1, ef0;
      logic        eo1, eo0;
      logic [15:0] rm, rr;
      logic        rs;
      int          acc[$];
      int          seen;

      vecs[0] = '{16'h0003, 16'hFFFB, 1'b1, 32'hFFFFFFF1, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      vecs[1] = '{16'h0600, 16'h0800, 1'b1, 32'h00300000, 16'h0C00, 1'b0, 16'h0C00, 1'b0};
      vecs[2] = '{16'h0200, 16'h0001, 1'b1, 32'h00000200, 16'h0001, 1'b0, 16'h0000, 1'b0};
      vecs[3] = '{16'h8000, 16'h8000, 1'b1, 32'h40000000, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};
      vecs[4] = '{16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 16'h8000, 1'b1, 16'h8000, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 16'h0000, 1'b0, 16'h0000, 1'b0};
      vecs[7] = '{16'h0400, 16'h0400, 1'b0, 32'h00100000, 16'h0400, 1'b0, 16'h0400, 1'b0};
      vecs[8] = '{16'hFE00, 16'h0001, 1'b1, 32'hFFFFFE00, 16'h0000, 1'b0, 16'hFFFF, 1'b0};
      vecs[9] = '{16'h7FFF, 16'h7FFF, 1'b1, 32'h3FFF0001, 16'h7FFF, 1'b1, 16'h7FFF, 1'b1};

      // Reset state while reset is held low
      #3;
      chk("reset_state", 64'({in_ready, out_valid, product, fixed_result, overflow}),
          64'({1'b1, 1'b0, 32'h0, 16'h0, 1'b0}));
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Directed table
      foreach (vecs[i])
         run_op($sformatf("vec%0d", i), vecs[i].m, vecs[i].r, vecs[i].sg,
                vecs[i].p, vecs[i].f1, vecs[i].o1, vecs[i].f0, vecs[i].o0, 0);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         rm = 16'($urandom); rr = 16'($urandom); rs = 1'($urandom_range(0, 1));
         if (i % 4 == 0) rm = (rm & 16'h00FF) | 16'h0100;   // mid-range Q values
         model(rm, rr, rs, 1'b1, ep, ef1, eo1);
         model(rm, rr, rs, 1'b0, ep, ef0, eo0);
         run_op($sformatf("rand%0d", i), rm, rr, rs, ep, ef1, eo1, ef0, eo0, 0);
      end

      // Backpressure: 20 stalled cycles with in_valid pulses, then a back-to-back op
      run_op("bp", 16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, 16'h8000, 1'b1, 16'h8000, 1'b1, 20);
      run_op("bp_next", 16'h0600, 16'h0800, 1'b1, 32'h00300000, 16'h0C00, 1'b0, 16'h0C00, 1'b0, 0);

      // Throughput with in_valid and out_ready held high
      @(negedge clk);
      M = 16'h0600; R = 16'h0800; is_signed = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (in_ready) acc.push_back(c);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("tput_accepts", 64'(acc.size() >= 3), 64'd1);
      if (acc.size() >= 3) begin
         chk("tput_interval0", 64'(acc[1] - acc[0]), 64'd11);
         chk("tput_interval1", 64'(acc[2] - acc[1]), 64'd11);
      end
      repeat (15) @(negedge clk);
      out_ready = 1'b0;

      // Leave non-zero results behind, then abort an operation with reset
      run_op("pre_abort", 16'h0600, 16'h0800, 1'b1, 32'h00300000, 16'h0C00, 1'b0, 16'h0C00, 1'b0, 0);
      @(negedge clk);
      M = 16'h7FFF; R = 16'h7FFF; is_signed = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_outputs", 64'({out_valid, in_ready, product, fixed_result, overflow}),
          64'({1'b0, 1'b1, 32'h0, 16'h0, 1'b0}));
      chk("abort_outputs_trunc", 64'({out_valid_t, in_ready_t, product_t, fixed_result_t, overflow_t}),
          64'({1'b0, 1'b1, 32'h0, 16'h0, 1'b0}));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (15) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      chk("abort_no_out_valid", 64'(seen), 64'd0);
      run_op("post_abort", 16'h0600, 16'h0800, 1'b1, 32'h00300000, 16'h0C00, 1'b0, 16'h0C00, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
